// File: rtl/fetch_sequencer.sv
// fetch_sequencer: IF-stage PC owner for the instruction ROM.
// Handles sequential fetch, stall hold, branch redirect, exception entry,
// ERET return and fetch address-error (AdEL) flagging.
// Optional build macro FETCH_PERF_EN adds saturating fetch/stall counters.
module fetch_sequencer #(
  parameter logic [31:0] PC_RESET    = 32'h0000_3000,
  parameter logic [31:0] HANDLER_VEC = 32'h0000_4180,
  parameter int unsigned ROM_WORDS   = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic [31:0] pc,
  output logic [11:0] im_addr,
  output logic        im_exc,
  output logic        fetch_adel,
  output logic        fetch_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt
`endif
);

  localparam logic [31:0] PC_LAST = PC_RESET + (32'(ROM_WORDS) << 2) - 32'd4;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic        adel;

  // State and PC registers; reset returns to the ROM base in BOOT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= BOOT;
      pc    <= PC_RESET;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Next-state / next-PC selection: exception, eret, stall, branch, sequential
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      BOOT: state_nxt = RUN;
      RUN, FLUSH: begin
        if (exc_req) begin
          pc_nxt    = HANDLER_VEC;
          state_nxt = FLUSH;
        end else if (eret) begin
          pc_nxt    = epc;
          state_nxt = FLUSH;
        end else if (state == FLUSH) begin
          state_nxt = RUN;
        end else if (!stall) begin
          if (br_taken) pc_nxt = br_target;
          else          pc_nxt = pc + 32'd4;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  // Address check and fetch qualification; bubbles outside RUN
  always_comb begin
    adel        = (pc[1:0] != 2'b00) || (pc < PC_RESET) || (pc > PC_LAST);
    im_exc      = 1'b1;
    fetch_valid = 1'b0;
    fetch_adel  = 1'b0;
    if (state == RUN) begin
      fetch_adel  = adel;
      im_exc      = adel;
      fetch_valid = !adel;
    end
  end

  // Word index of pc in the ROM; the base is word aligned, so the low
  // two bits cannot borrow and a 12-bit subtract on [13:2] suffices
  assign im_addr = pc[13:2] - PC_RESET[13:2];

`ifdef FETCH_PERF_EN
  // Saturating counters for delivered fetches and RUN-state stall cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (fetch_valid && !stall && (fetch_cnt != '1))
        fetch_cnt <= fetch_cnt + 32'd1;
      if ((state == RUN) && stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by
// randomized traffic compared against a behavioural model of the PC rules.
module tb_fetch_sequencer;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret;
  logic [31:0] epc;
  logic [31:0] pc;
  logic [11:0] im_addr;
  logic        im_exc;
  logic        fetch_adel;
  logic        fetch_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;
`endif

  int tests = 0;
  int fails = 0;

  // model state: pc plus "bubble" flags for post-reset and post-redirect cycles
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_flush;
  logic [31:0] m_fc;
  logic [31:0] m_sc;

  fetch_sequencer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .stall       (stall),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .exc_req     (exc_req),
    .eret        (eret),
    .epc         (epc),
    .pc          (pc),
    .im_addr     (im_addr),
    .im_exc      (im_exc),
    .fetch_adel  (fetch_adel),
    .fetch_valid (fetch_valid)
`ifdef FETCH_PERF_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .stall_cnt   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit bad_addr(input logic [31:0] a);
    return (a % 4 != 0) || (a < 32'h3000) || (a > 32'h6FFC);
  endfunction

  task automatic model_reset();
    m_pc = 32'h3000; m_boot = 1'b1; m_flush = 1'b0; m_fc = '0; m_sc = '0;
  endtask

  // advance one clock, update the model with the inputs seen at the edge
  task automatic step();
    bit run;
    run = reset_n && !m_boot && !m_flush;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (run && !bad_addr(m_pc) && !stall && m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
      if (run && stall && m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
      if (m_boot)        m_boot = 1'b0;
      else if (exc_req)  begin m_pc = 32'h4180; m_flush = 1'b1; end
      else if (eret)     begin m_pc = epc; m_flush = 1'b1; end
      else if (m_flush)  m_flush = 1'b0;
      else if (stall)    m_pc = m_pc;
      else if (br_taken) m_pc = br_target;
      else               m_pc = m_pc + 32'd4;
    end
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; br_taken = 0; br_target = '0; exc_req = 0; eret = 0; epc = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_inputs();
    model_reset();
    step(); step();
    tests++; if (pc !== 32'h3000) begin fails++; $display("FAIL reset_pc: got %h want %h", pc, 32'h3000); end
    tests++; if (fetch_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", fetch_valid); end
    tests++; if (im_exc !== 1'b1) begin fails++; $display("FAIL reset_imexc: got %b want 1", im_exc); end
    tests++; if (fetch_adel !== 1'b0) begin fails++; $display("FAIL reset_adel: got %b want 0", fetch_adel); end
    reset_n = 1'b1;
    #1;
    tests++; if (pc !== 32'h3000 || fetch_valid !== 1'b0) begin fails++; $display("FAIL boot_cycle: got pc=%h valid=%b want pc=3000 valid=0", pc, fetch_valid); end
    step();
    tests++; if (pc !== 32'h3000 || fetch_valid !== 1'b1 || im_addr !== 12'd0) begin fails++; $display("FAIL first_run: got pc=%h valid=%b addr=%0d want 3000/1/0", pc, fetch_valid, im_addr); end
    step();
    tests++; if (pc !== 32'h3004 || im_addr !== 12'd1) begin fails++; $display("FAIL seq1: got pc=%h addr=%0d want 3004/1", pc, im_addr); end
    step();
    tests++; if (pc !== 32'h3008 || im_addr !== 12'd2) begin fails++; $display("FAIL seq2: got pc=%h addr=%0d want 3008/2", pc, im_addr); end
  endtask

  task automatic test_stall_branch();
    step(); step();
    tests++; if (pc !== 32'h3010) begin fails++; $display("FAIL reach_3010: got %h want 3010", pc); end
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      tests++; if (pc !== 32'h3010) begin fails++; $display("FAIL stall_hold%0d: got %h want 3010", i, pc); end
    end
    stall = 1'b0; br_taken = 1'b1; br_target = 32'h3100;
    step();
    tests++; if (pc !== 32'h3100 || im_addr !== 12'h40) begin fails++; $display("FAIL branch: got pc=%h addr=%h want 3100/040", pc, im_addr); end
    clear_inputs();
  endtask

  task automatic test_exception();
    br_taken = 1'b1; br_target = 32'h3020;
    step();
    tests++; if (pc !== 32'h3020) begin fails++; $display("FAIL reach_3020: got %h want 3020", pc); end
    exc_req = 1'b1; stall = 1'b1; br_taken = 1'b1; br_target = 32'h3100;
    step();
    tests++; if (pc !== 32'h4180 || im_exc !== 1'b1 || fetch_valid !== 1'b0) begin fails++; $display("FAIL exc_flush: got pc=%h imexc=%b valid=%b want 4180/1/0", pc, im_exc, fetch_valid); end
    clear_inputs();
    step();
    tests++; if (pc !== 32'h4180 || im_addr !== 12'd1120 || fetch_valid !== 1'b1) begin fails++; $display("FAIL exc_handler: got pc=%h addr=%0d valid=%b want 4180/1120/1", pc, im_addr, fetch_valid); end
  endtask

  task automatic test_eret_in_flush();
    exc_req = 1'b1;
    step();
    exc_req = 1'b0; eret = 1'b1; epc = 32'h3024;
    step();
    tests++; if (pc !== 32'h3024 || im_exc !== 1'b1 || fetch_valid !== 1'b0) begin fails++; $display("FAIL eret_flush: got pc=%h imexc=%b valid=%b want 3024/1/0", pc, im_exc, fetch_valid); end
    clear_inputs();
    step();
    tests++; if (pc !== 32'h3024 || fetch_valid !== 1'b1 || im_addr !== 12'd9) begin fails++; $display("FAIL eret_run: got pc=%h valid=%b addr=%0d want 3024/1/9", pc, fetch_valid, im_addr); end
  endtask

  task automatic test_adel();
    br_taken = 1'b1; br_target = 32'h3002;
    step();
    tests++; if (fetch_adel !== 1'b1 || im_exc !== 1'b1 || fetch_valid !== 1'b0) begin fails++; $display("FAIL adel_misalign: got adel=%b imexc=%b valid=%b want 1/1/0", fetch_adel, im_exc, fetch_valid); end
    br_target = 32'h7000;
    step();
    tests++; if (fetch_adel !== 1'b1) begin fails++; $display("FAIL adel_high: got %b want 1", fetch_adel); end
    br_target = 32'h6FFC;
    step();
    tests++; if (fetch_adel !== 1'b0 || im_addr !== 12'd4095 || fetch_valid !== 1'b1) begin fails++; $display("FAIL last_word: got adel=%b addr=%0d valid=%b want 0/4095/1", fetch_adel, im_addr, fetch_valid); end
    br_target = 32'h2FFC;
    step();
    tests++; if (fetch_adel !== 1'b1) begin fails++; $display("FAIL adel_low: got %b want 1", fetch_adel); end
    br_target = 32'hFFFF_FFFC;
    step();
    br_taken = 1'b0;
    step();
    tests++; if (pc !== 32'h0 || fetch_adel !== 1'b1) begin fails++; $display("FAIL wrap: got pc=%h adel=%b want 00000000/1", pc, fetch_adel); end
    br_taken = 1'b1; br_target = 32'h3000;
    step();
    clear_inputs();
  endtask

  task automatic test_async_reset();
    stall = 1'b1;
    step(); step();
    tests++; if (pc !== m_pc) begin fails++; $display("FAIL pre_reset_hold: got %h want %h", pc, m_pc); end
    #3;
    reset_n = 1'b0;
    #1;
    model_reset();
    tests++; if (pc !== 32'h3000 || im_exc !== 1'b1 || fetch_valid !== 1'b0 || fetch_adel !== 1'b0) begin fails++; $display("FAIL async_reset: got pc=%h imexc=%b valid=%b adel=%b want 3000/1/0/0", pc, im_exc, fetch_valid, fetch_adel); end
`ifdef FETCH_PERF_EN
    tests++; if (fetch_cnt !== 32'd0 || stall_cnt !== 32'd0) begin fails++; $display("FAIL async_reset_cnt: got %0d/%0d want 0/0", fetch_cnt, stall_cnt); end
`endif
    step();
    reset_n = 1'b1;
    #1;
    tests++; if (pc !== 32'h3000 || fetch_valid !== 1'b0) begin fails++; $display("FAIL reboot: got pc=%h valid=%b want 3000/0", pc, fetch_valid); end
    step();
    tests++; if (pc !== 32'h3000 || fetch_valid !== 1'b1) begin fails++; $display("FAIL reboot_run: got pc=%h valid=%b want 3000/1", pc, fetch_valid); end
    clear_inputs();
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 9))
      0:       return $urandom;
      1:       return 32'h3000 + 4 * $urandom_range(0, 4095) + $urandom_range(1, 3);
      2:       return 32'h6FFC;
      3:       return 32'hFFFF_FFFC;
      default: return 32'h3000 + 4 * $urandom_range(0, 4095);
    endcase
  endfunction

  task automatic test_random();
    bit run, ad;
    for (int i = 0; i < 600; i++) begin
      exc_req   = ($urandom_range(0, 15) == 0);
      eret      = ($urandom_range(0, 15) == 0);
      stall     = ($urandom_range(0, 3) == 0);
      br_taken  = ($urandom_range(0, 3) == 0);
      br_target = rand_addr();
      epc       = rand_addr();
      step();
      run = !m_boot && !m_flush;
      ad  = bad_addr(m_pc);
      tests++; if (pc !== m_pc) begin fails++; $display("FAIL rnd_pc[%0d]: got %h want %h", i, pc, m_pc); end
      tests++; if (fetch_valid !== (run && !ad)) begin fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, fetch_valid, run && !ad); end
      tests++; if (im_exc !== (!run || ad)) begin fails++; $display("FAIL rnd_imexc[%0d]: got %b want %b", i, im_exc, !run || ad); end
      tests++; if (fetch_adel !== (run && ad)) begin fails++; $display("FAIL rnd_adel[%0d]: got %b want %b", i, fetch_adel, run && ad); end
      if (run && !ad) begin
        tests++; if (im_addr !== 12'((m_pc - 32'h3000) / 4)) begin fails++; $display("FAIL rnd_addr[%0d]: got %0d want %0d", i, im_addr, 12'((m_pc - 32'h3000) / 4)); end
      end
`ifdef FETCH_PERF_EN
      tests++; if (fetch_cnt !== m_fc || stall_cnt !== m_sc) begin fails++; $display("FAIL rnd_cnt[%0d]: got %0d/%0d want %0d/%0d", i, fetch_cnt, stall_cnt, m_fc, m_sc); end
`endif
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_stall_branch();
    test_exception();
    test_eret_in_flush();
    test_adel();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d tests run", tests);
    $fatal(1, "timeout");
  end

endmodule
